memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the five-stage RV64 pipeline: the consumer end of the execute→memory interface. It takes `excute_data_t` from execute and performs the load/store on the data bus. It stalls execute through `stopm` while a bus transaction is outstanding, and registers the result as `memory_data_t` for writeback. Non-memory instructions pass through in one cycle.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; `reset==0` at posedge resets.
- `flushm` in 1: discard the instruction currently in the stage (exception/redirect).
- `dataE` in `excute_data_t`: execute output; held stable by execute while `stopm==1`.
- `dataM` out `memory_data_t`: registered stage output (valid, pc, instr, ctl, dst, result, csr, csrdst, error).
- `stopm` out 1: stall to execute; combinational.
- `dreq` out `dbus_req_t`: valid, addr[63:0], size `msize_t`, strobe[7:0], data[63:0].
- `dresp` in `dbus_resp_t`: addr_ok, data_ok, data[63:0].

## Operation
- Memory op: `dataE.valid && ctl.op ∈ {LOAD, STORE}`. Width/sign come from `funct3 = instr[14:12]`:
  - 0 = B, 1 = H, 2 = W, 3 = D, 4 = BU, 5 = HU, 6 = WU.
  - Address is `dataE.result`; store data is `dataE.rd2`.
- Misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0):
  - No bus request.
  - Completes in one cycle with `dataM.error = 1`.
  - Incoming `dataE.error` is ORed in for all instructions.
- Store:
  - `strobe = mask(size) << addr[2:0]`, with mask = 0x01/0x03/0x0F/0xFF.
  - `data = rd2 << (8*addr[2:0])`.
- Load:
  - `strobe = 0`.
  - `result = ext(dresp.data >> (8*addr[2:0]))`, sign- or zero-extended to 64 bits per funct3.
- `dreq.addr = dataE.result` (unmodified); `dreq.size` = width.
- FSM states:
  - **IDLE**:
    - Aligned memory op → drive `dreq.valid = 1` combinationally.
    - If `data_ok` arrives the same cycle, complete; otherwise go to WAIT.
  - **WAIT**:
    - Hold `dreq.valid` and all fields from the stable `dataE`.
    - On `data_ok`: complete, go to IDLE.
  - **DRAIN**:
    - Entered when `flushm` is seen in WAIT.
    - Keep `dreq` asserted, because the bus forbids withdrawing a request.
    - On `data_ok`: go to IDLE; the result is discarded.
- `stopm = (memory op aligned && !data_ok) || state == DRAIN`.
- `dataM` update at posedge:
  - `reset == 0` or `flushm` → `dataM.valid <= 0`.
  - Else if `!stopm` → load all fields from `dataE`. `result` is the load data for loads and `dataE.result` otherwise; `valid <= dataE.valid`.
  - Else (`stopm`) → `dataM.valid <= 0` (bubble).
- `addr_ok` is ignored: completion is defined by `data_ok` only.

## Timing
- Reset values:
  - `dataM.valid = 0`, other `dataM` fields unspecified.
  - state = IDLE, `dreq.valid = 0`, `stopm = 0`.
- Non-memory or misaligned instruction: latency 1 cycle, no stall.
- Memory op with `data_ok` k cycles after `dreq.valid` rises (k ≥ 0): `stopm` high k cycles; `dataM` valid at posedge k+1.
- `dreq` fields are constant from assertion until `data_ok` inclusive.
- `data_ok` without a pending request is ignored.
- `reset` low in WAIT or DRAIN: state goes to IDLE and `dreq.valid` drops the next cycle; the bus is reset by the same signal.
- `flushm` in IDLE with a pending op whose `data_ok` arrives the same cycle: the op completes on the bus, `dataM.valid = 0`, state stays IDLE.
- Back-to-back memory ops: a new request may assert in the cycle immediately after `data_ok`.

## Structure
- `pipes` package: `memory_data_t`.
- `common` package: `dbus_req_t`, `dbus_resp_t`, `msize_t` (MSIZE1/2/4/8), state enum `mstate_t`.
- Sub-module `mem_align` (combinational): inputs addr[2:0], funct3, rd2, resp data. Outputs size, strobe, wdata, rdata-extended, misaligned.
- FSM and pipeline register live in `memory_stage`.

## Test plan
- ADD passthrough, `dataE.result = 0x1234` → `dataM.result = 0x1234` next cycle; `stopm` never high; `dreq.valid = 0`.
- LW at 0x80000004, `data_ok` after 3 cycles with data 0xDEADBEEF_12345678:
  - `stopm` high for 3 cycles.
  - `dataM.result = 0xFFFFFFFF_DEADBEEF`.
  - Same test with LWU → 0x00000000_DEADBEEF.
- SB at 0x80000003, rd2 = 0xAB → `strobe = 0x08`, `dreq.data = 0x00000000_AB000000`, `size = MSIZE1`; zero-wait `data_ok` → no stall.
- LH at 0x80000001 → no `dreq.valid`; `dataM.error = 1` after 1 cycle; `stopm = 0`.
- `flushm` during WAIT:
  - `dreq` stays asserted until `data_ok` (2 cycles later).
  - `dataM.valid = 0` throughout.
  - Next LD issues the cycle after `data_ok`.
- `reset = 0` mid-WAIT → next cycle `dreq.valid = 0`, `stopm = 0`, `dataM.valid = 0`.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: data-bus transaction types and the
// execute/memory pipeline records.
package common;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} mstate_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

package pipes;
  typedef enum logic [2:0] {
    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_CSR
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rd2;
    logic [63:0] csr;
    logic [11:0] csrdst;
    logic        error;
  } excute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] csr;
    logic [11:0] csrdst;
    logic        error;
  } memory_data_t;
endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for the data bus: store strobe/data placement, load
// extraction with sign/zero extension, and natural-alignment check.
module mem_align
  import common::*;
(
  input  logic [2:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] rd2_i,
  input  logic [63:0] rdata_i,
  output msize_t      size_o,
  output logic [7:0]  strobe_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_ext_o,
  output logic        misaligned_o
);
  logic [7:0]  mask;
  logic [63:0] shifted;

  // funct3[1:0] encodes log2(bytes); funct3[2] selects zero extension.
  assign size_o = msize_t'(funct3_i[1:0]);

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    mask         = 8'hFF;
    misaligned_o = 1'b0;
    unique case (size_o)
      MSIZE1: mask = 8'h01;
      MSIZE2: begin mask = 8'h03; misaligned_o = addr_i[0];     end
      MSIZE4: begin mask = 8'h0F; misaligned_o = |addr_i[1:0];  end
      MSIZE8: begin mask = 8'hFF; misaligned_o = |addr_i;       end
      default: ;
    endcase
  end

  assign strobe_o = mask << addr_i;
  assign wdata_o  = rd2_i << {addr_i, 3'b000};
  assign shifted  = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    rdata_ext_o = shifted;
    unique case (funct3_i)
      3'd0: rdata_ext_o = {{56{shifted[7]}},  shifted[7:0]};
      3'd1: rdata_ext_o = {{48{shifted[15]}}, shifted[15:0]};
      3'd2: rdata_ext_o = {{32{shifted[31]}}, shifted[31:0]};
      3'd4: rdata_ext_o = {56'd0, shifted[7:0]};
      3'd5: rdata_ext_o = {48'd0, shifted[15:0]};
      3'd6: rdata_ext_o = {32'd0, shifted[31:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, stalls
// execute while a transaction is outstanding, and registers the result.
module memory_stage
  import common::*;
  import pipes::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flushm,
  input  excute_data_t dataE,
  output memory_data_t dataM,
  output logic         stopm,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp
);
  mstate_t      state_q, state_d;
  memory_data_t data_q;
  dbus_req_t    req_now, req_q;

  logic         is_load, is_store, mem_op, aligned_op, misaligned;
  msize_t       size;
  logic [7:0]   strobe;
  logic [63:0]  wdata, rdata_ext;
  logic         unused_addr_ok;

  mem_align u_align (
    .addr_i       (dataE.result[2:0]),
    .funct3_i     (dataE.instr[14:12]),
    .rd2_i        (dataE.rd2),
    .rdata_i      (dresp.data),
    .size_o       (size),
    .strobe_o     (strobe),
    .wdata_o      (wdata),
    .rdata_ext_o  (rdata_ext),
    .misaligned_o (misaligned)
  );

  assign is_load        = dataE.ctl.op == OP_LOAD;
  assign is_store       = dataE.ctl.op == OP_STORE;
  assign mem_op         = dataE.valid && (is_load || is_store);
  assign aligned_op     = mem_op && !misaligned;
  assign unused_addr_ok = dresp.addr_ok;

  always_comb begin
    req_now        = '0;
    req_now.addr   = dataE.result;
    req_now.size   = size;
    req_now.strobe = is_store ? strobe : 8'h00;
    req_now.data   = wdata;
  end

  always_comb begin
    state_d = state_q;
    dreq    = req_now;
    unique case (state_q)
      S_IDLE: begin
        if (aligned_op) begin
          dreq.valid = 1'b1;
          // A flushed op that cannot finish now must still be seen through.
          if (!dresp.data_ok) state_d = flushm ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        dreq.valid = 1'b1;
        if (dresp.data_ok) state_d = S_IDLE;
        else if (flushm)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Replay the captured request: execute may already hold something else.
        dreq       = req_q;
        dreq.valid = 1'b1;
        if (dresp.data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stopm = (aligned_op && !dresp.data_ok) || (state_q == S_DRAIN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (state_q != S_DRAIN) req_q <= req_now;
  end

  // NOTE: only the valid bit is reset; payload fields are qualified by it,
  // so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset || flushm) begin
      data_q.valid <= 1'b0;
    end else if (!stopm) begin
      data_q.valid  <= dataE.valid;
      data_q.pc     <= dataE.pc;
      data_q.instr  <= dataE.instr;
      data_q.ctl    <= dataE.ctl;
      data_q.dst    <= dataE.dst;
      data_q.result <= (is_load && !misaligned) ? rdata_ext : dataE.result;
      data_q.csr    <= dataE.csr;
      data_q.csrdst <= dataE.csrdst;
      data_q.error  <= dataE.error | (mem_op && misaligned);
    end else begin
      data_q.valid <= 1'b0;
    end
  end

  assign dataM = data_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus sequences
// for wait states, flush-drain, reset mid-transaction and flush in IDLE.
module tb_memory_stage;
  import common::*;
  import pipes::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         flushm;
  excute_data_t dataE;
  memory_data_t dataM;
  logic         stopm;
  dbus_req_t    dreq;
  dbus_resp_t   dresp;

  int checks = 0;
  int errors = 0;

  memory_stage dut (
    .clk    (clk),
    .reset  (reset),
    .flushm (flushm),
    .dataE  (dataE),
    .dataM  (dataM),
    .stopm  (stopm),
    .dreq   (dreq),
    .dresp  (dresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input op_t op, input logic [2:0] f3, input logic [63:0] res,
                       input logic [63:0] rd2, input logic err, input logic vld);
    dataE        = '0;
    dataE.valid  = vld;
    dataE.pc     = 64'h8000_1000;
    dataE.instr  = {17'd0, f3, 12'h003};
    dataE.ctl.op = op;
    dataE.dst    = 5'd7;
    dataE.result = res;
    dataE.rd2    = rd2;
    dataE.error  = err;
  endtask

  task automatic bubble();
    dataE = '0;
    dresp = '0;
  endtask

  typedef struct {
    op_t         op;
    logic [2:0]  f3;
    logic [63:0] res;
    logic [63:0] rd2;
    logic        in_err;
    logic        in_valid;
    logic        ok;
    logic [63:0] rdata;
    logic        e_req;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    msize_t      e_size;
    logic        e_mvalid;
    logic [63:0] e_result;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic run_load(input logic [2:0] f3, input int k, input logic [63:0] exp);
    int stalls = 0;
    drive(OP_LOAD, f3, 64'h8000_0004, 64'd0, 1'b0, 1'b1);
    dresp = '0;
    for (int i = 0; i < k; i++) begin
      #2;
      if (stopm) stalls++;
      check("wait_dreq_valid", 64'(dreq.valid), 64'd1);
      check("wait_dreq_addr", dreq.addr, 64'h8000_0004);
      check("wait_dreq_size", 64'(dreq.size), 64'(MSIZE4));
      @(posedge clk); #1;
      check("wait_dataM_valid", 64'(dataM.valid), 64'd0);
    end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hDEAD_BEEF_1234_5678;
    #2;
    check("done_stopm", 64'(stopm), 64'd0);
    check("done_dreq_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    check("stall_cycles", 64'(stalls), 64'(k));
    check("load_valid", 64'(dataM.valid), 64'd1);
    check("load_result", dataM.result, exp);
    bubble();
  endtask

  initial begin
    // op f3 res rd2 err vld ok rdata | req strb wdata size mvalid result err
    vecs.push_back('{OP_ALU,   3'd0, 64'h1234,      64'd0, 0, 1, 0, 64'd0,
                     0, 8'h00, 64'd0, MSIZE1, 1, 64'h1234, 0});
    vecs.push_back('{OP_ALU,   3'd0, 64'h55,        64'd0, 0, 1, 1, 64'hFFFF,
                     0, 8'h00, 64'd0, MSIZE1, 1, 64'h55, 0});
    vecs.push_back('{OP_STORE, 3'd0, 64'h8000_0003, 64'hAB, 0, 1, 1, 64'd0,
                     1, 8'h08, 64'h0000_0000_AB00_0000, MSIZE1, 1, 64'h8000_0003, 0});
    vecs.push_back('{OP_LOAD,  3'd1, 64'h8000_0001, 64'd0, 0, 1, 0, 64'd0,
                     0, 8'h00, 64'd0, MSIZE2, 1, 64'h8000_0001, 1});
    vecs.push_back('{OP_LOAD,  3'd0, 64'h105,       64'd0, 0, 1, 1, 64'h0012_8000_0000_0000,
                     1, 8'h00, 64'd0, MSIZE1, 1, 64'hFFFF_FFFF_FFFF_FF80, 0});
    vecs.push_back('{OP_LOAD,  3'd4, 64'h105,       64'd0, 0, 1, 1, 64'h0012_8000_0000_0000,
                     1, 8'h00, 64'd0, MSIZE1, 1, 64'h80, 0});
    vecs.push_back('{OP_LOAD,  3'd1, 64'h106,       64'd0, 0, 1, 1, 64'h0012_8000_0000_0000,
                     1, 8'h00, 64'd0, MSIZE2, 1, 64'h12, 0});
    vecs.push_back('{OP_STORE, 3'd3, 64'h1000, 64'h1122_3344_5566_7788, 0, 1, 1, 64'd0,
                     1, 8'hFF, 64'h1122_3344_5566_7788, MSIZE8, 1, 64'h1000, 0});
    vecs.push_back('{OP_STORE, 3'd1, 64'h2002,      64'hBEEF, 0, 1, 1, 64'd0,
                     1, 8'h0C, 64'h0000_0000_BEEF_0000, MSIZE2, 1, 64'h2002, 0});
    vecs.push_back('{OP_STORE, 3'd2, 64'h2006,      64'h1, 0, 1, 0, 64'd0,
                     0, 8'h00, 64'd0, MSIZE4, 1, 64'h2006, 1});
    vecs.push_back('{OP_LOAD,  3'd3, 64'h8,         64'd0, 0, 1, 1, 64'hCAFE_BABE_0000_0001,
                     1, 8'h00, 64'd0, MSIZE8, 1, 64'hCAFE_BABE_0000_0001, 0});
    vecs.push_back('{OP_ALU,   3'd0, 64'h77,        64'd0, 1, 1, 0, 64'd0,
                     0, 8'h00, 64'd0, MSIZE1, 1, 64'h77, 1});
    vecs.push_back('{OP_LOAD,  3'd3, 64'h10,        64'd0, 0, 0, 0, 64'd0,
                     0, 8'h00, 64'd0, MSIZE8, 0, 64'h10, 0});
    vecs.push_back('{OP_LOAD,  3'd6, 64'h4,         64'd0, 0, 1, 1, 64'hDEAD_BEEF_1234_5678,
                     1, 8'h00, 64'd0, MSIZE4, 1, 64'hDEAD_BEEF, 0});
    vecs.push_back('{OP_LOAD,  3'd5, 64'h2,         64'd0, 0, 1, 1, 64'h0000_0000_8001_0000,
                     1, 8'h00, 64'd0, MSIZE2, 1, 64'h8001, 0});

    reset  = 1'b0;
    flushm = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dataM_valid", 64'(dataM.valid), 64'd0);
    check("reset_stopm", 64'(stopm), 64'd0);
    check("reset_dreq_valid", 64'(dreq.valid), 64'd0);
    reset = 1'b1;

    foreach (vecs[n]) begin
      drive(vecs[n].op, vecs[n].f3, vecs[n].res, vecs[n].rd2, vecs[n].in_err, vecs[n].in_valid);
      dresp.addr_ok = 1'b0;
      dresp.data_ok = vecs[n].ok;
      dresp.data    = vecs[n].rdata;
      #2;
      check($sformatf("v%0d_dreq_valid", n), 64'(dreq.valid), 64'(vecs[n].e_req));
      check($sformatf("v%0d_stopm", n), 64'(stopm), 64'd0);
      if (vecs[n].e_req) begin
        check($sformatf("v%0d_strobe", n), 64'(dreq.strobe), 64'(vecs[n].e_strb));
        check($sformatf("v%0d_wdata", n), dreq.data, vecs[n].e_wdata);
        check($sformatf("v%0d_size", n), 64'(dreq.size), 64'(vecs[n].e_size));
        check($sformatf("v%0d_addr", n), dreq.addr, vecs[n].res);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_dataM_valid", n), 64'(dataM.valid), 64'(vecs[n].e_mvalid));
      if (vecs[n].e_mvalid) begin
        check($sformatf("v%0d_result", n), dataM.result, vecs[n].e_result);
        check($sformatf("v%0d_error", n), 64'(dataM.error), 64'(vecs[n].e_err));
      end
    end
    bubble();
    @(posedge clk); #1;

    run_load(3'd2, 3, 64'hFFFF_FFFF_DEAD_BEEF);
    run_load(3'd6, 3, 64'h0000_0000_DEAD_BEEF);

    // Flush while waiting: request must persist until data_ok, then a new LD.
    drive(OP_LOAD, 3'd3, 64'h100, 64'd0, 1'b0, 1'b1);
    dresp = '0;
    #2;
    check("fl_issue_valid", 64'(dreq.valid), 64'd1);
    check("fl_issue_stopm", 64'(stopm), 64'd1);
    @(posedge clk); #1;
    flushm = 1'b1;
    #2;
    check("fl_wait_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    check("fl_dataM_valid", 64'(dataM.valid), 64'd0);
    flushm = 1'b0;
    bubble();
    for (int i = 0; i < 2; i++) begin
      dresp.data_ok = (i == 1);
      dresp.data    = 64'h5555;
      #2;
      check($sformatf("drain%0d_valid", i), 64'(dreq.valid), 64'd1);
      check($sformatf("drain%0d_addr", i), dreq.addr, 64'h100);
      check($sformatf("drain%0d_size", i), 64'(dreq.size), 64'(MSIZE8));
      check($sformatf("drain%0d_stopm", i), 64'(stopm), 64'd1);
      @(posedge clk); #1;
      check($sformatf("drain%0d_dataM_valid", i), 64'(dataM.valid), 64'd0);
    end
    drive(OP_LOAD, 3'd3, 64'h200, 64'd0, 1'b0, 1'b1);
    dresp = '0;
    #2;
    check("b2b_valid", 64'(dreq.valid), 64'd1);
    check("b2b_addr", dreq.addr, 64'h200);
    @(posedge clk); #1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0123_4567_89AB_CDEF;
    #2;
    check("b2b_stopm", 64'(stopm), 64'd0);
    @(posedge clk); #1;
    check("b2b_dataM_valid", 64'(dataM.valid), 64'd1);
    check("b2b_result", dataM.result, 64'h0123_4567_89AB_CDEF);
    bubble();

    // Reset in the middle of a wait.
    drive(OP_LOAD, 3'd2, 64'h8000_0004, 64'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    bubble();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
    check("rst_stopm", 64'(stopm), 64'd0);
    check("rst_dataM_valid", 64'(dataM.valid), 64'd0);
    @(posedge clk); #1;

    // Flush in IDLE while the op completes immediately on the bus.
    drive(OP_STORE, 3'd3, 64'h300, 64'h42, 1'b0, 1'b1);
    dresp.data_ok = 1'b1;
    flushm = 1'b1;
    #2;
    check("fi_dreq_valid", 64'(dreq.valid), 64'd1);
    check("fi_stopm", 64'(stopm), 64'd0);
    @(posedge clk); #1;
    check("fi_dataM_valid", 64'(dataM.valid), 64'd0);
    flushm = 1'b0;
    drive(OP_ALU, 3'd0, 64'h99, 64'd0, 1'b0, 1'b1);
    dresp = '0;
    #2;
    check("fi_next_dreq", 64'(dreq.valid), 64'd0);
    check("fi_next_stopm", 64'(stopm), 64'd0);
    @(posedge clk); #1;
    check("fi_next_valid", 64'(dataM.valid), 64'd1);
    check("fi_next_result", dataM.result, 64'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
